s1_serial_tx: RTL and testbench
===============================

# s1_serial_tx

Upstream serial transmitter that feeds the S2 receiver. It reads an 18-word × 8-bit source buffer (RB1) and performs a bit-transpose: each of the 8 bit-planes becomes one 18-bit word. Each word is sent over the `sen`/`sd` serial link as an 8-packet stream, each packet a 3-bit address followed by 18 data bits, MSB first. `S1_done` asserts when the last packet has been sent.

## Interface
- Parameters: none; widths and counts are fixed by the S1/S2 link protocol (3-bit address, 18-bit data, 8 packets).
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- RB1_Q  input  8  RB1 read data. Synchronous RAM: the address on RB1_A is sampled at an edge, and RB1_Q is valid for the whole following cycle.
- RB1_RW  output  1  RB1 read/write select; constant 1 (read only).
- RB1_A  output  5  RB1 word address, 0..17; registered.
- sen  output  1  serial enable, active-low; 0 for every address and data bit of a packet; registered.
- sd  output  1  serial data bit; registered.
- S1_done  output  1  high once all 8 packets are sent; registered, sticky until reset.

## Operation
- Packet k (k = 0..7):
  - Address field = k, sent A2, A1, A0.
  - Data bit D[17-i] = RB1[i][7-k] for i = 0..17, sent D17 first through D0.
- FSM states:
  - IDLE: 1 cycle after reset release; go to ADDR with k = 0.
  - ADDR: 3 cycles, one address bit per cycle; go to DATA.
  - DATA: 18 cycles, sd = captured RB1_Q[7-k]; go to GAP.
  - GAP: 1 cycle, sen = 1, sd = 0. If k < 7, increment k and go to ADDR; else go to DONE.
  - DONE: terminal; sen = 1, sd = 0, S1_done = 1. Only rst leaves DONE.
- Counters:
  - Bit counter 0..17, reused for ADDR (0..2) and DATA (0..17); cleared on every state change.
  - Packet counter k, 3 bits. It must not wrap: DONE is entered instead of returning to k = 0.
- Read pipeline:
  - RB1_A = i is driven exactly 2 cycles before the cycle in which sd carries D[17-i].
  - RB1_Q is registered once into the sd flop, selecting bit 7-k.
  - The first read (RB1_A = 0) is issued during the second ADDR cycle, so no bubble appears between A0 and D17.
- RB1_A = 0 in every cycle not covered by the read schedule.
- Link contract with S2: sen = 1 for exactly one cycle between packets. S2 uses that cycle for its write-back and re-arm, so the gap may never be shortened to 0.
- Reset values: sen = 1, sd = 0, RB1_RW = 1, RB1_A = 0, S1_done = 0, state = IDLE, k = 0, bit counter = 0.
- rst asserted mid-packet:
  - Outputs go to reset values immediately (asynchronous).
  - After release, transmission restarts from packet 0; no partial packet is resumed.
- RB1_Q is never sampled outside DATA.

## Timing
- Cycle c = interval after rising edge c following rst deassert; cycle 0 = IDLE with reset values.
- Packet k base b = 1 + 22k:
  - Cycles b..b+2: ADDR, sen = 0, sd = A2, A1, A0.
  - Cycles b+3..b+20: DATA, sen = 0, sd = D17..D0.
  - Cycle b+21: GAP, sen = 1.
- RB1_A = i during cycle b+1+i, for i = 0..17. RB1_Q = RB1[i] is valid during cycle b+2+i and appears on sd in cycle b+3+i.
- Packet 7 GAP is at cycle 176. S1_done = 1 from cycle 177 onward.
- Total transmission: 176 link cycles. Throughput is 1 bit/cycle during packets.

## Test plan
- Reset check: hold rst, toggle clk → sen = 1, sd = 0, RB1_RW = 1, RB1_A = 0, S1_done = 0. Release rst → first sen = 0 in cycle 1.
- Transpose check: RB1[i] = 8'h80 for all i → packet 0 data = 18'h3FFFF with address 3'b000; packets 1..7 data = 0 with addresses 1..7.
- Pattern check: RB1[i] = i (i = 0..17) → packet 7 (bit 0 plane) data = 18'b010101010101010101 (D17 = RB1[0][0] = 0), address 3'b111. Packet 3 (bit 4 plane) data = 18'b000000000000000011.
- Protocol check: monitor sen → exactly 21 consecutive low cycles per packet, exactly 1 high cycle between packets. RB1_A sequence 0..17 leads sd by 2 cycles. Exactly 8 packets, S1_done rises at cycle 177.
- Mid-packet reset: assert rst in cycle 60 (packet 2, DATA) → sen = 1 immediately. After release, the next packet carries address 0 with packet-0 data.
- End-to-end: connect to an S2 instance, load random RB1 contents → RB2 holds the transposed words at addresses 0..7, and both S1_done and S2_done are asserted.

Source files
------------

// File: rtl/s1_serial_tx.sv
// s1_serial_tx: bit-transposing serial transmitter for the S1/S2 link.
// It reads 18 bytes from RB1 and sends 8 packets. Packet k carries bit-plane 7-k
// of those bytes: a 3-bit address, then 18 data bits, MSB first, with sen low.
// Every output is a flop. The next-state values are decoded first, and the
// output flops load from them, so each output matches the state it belongs to.
module s1_serial_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] RB1_Q,
    output logic       RB1_RW,
    output logic [4:0] RB1_A,
    output logic       sen,
    output logic       sd,
    output logic       S1_done
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] ADDR = 3'd1;
    localparam logic [2:0] DATA = 3'd2;
    localparam logic [2:0] GAP  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0] state_reg, state_next;
    logic [4:0] cnt_reg, cnt_next;
    logic [2:0] k_reg, k_next;
    logic       sen_next, sd_next, done_next;
    logic [4:0] addr_next;

    // The buffer is only ever read.
    assign RB1_RW = 1'b1;

    // State, bit counter and packet counter sequencing. IDLE uses the bit
    // counter to hold for exactly one full cycle after reset release.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        k_next     = k_reg;
        case (state_reg)
            IDLE: begin
                if (cnt_reg == 5'd0) begin
                    cnt_next = 5'd1;
                end else begin
                    state_next = ADDR;
                    cnt_next   = 5'd0;
                    k_next     = 3'd0;
                end
            end
            ADDR: begin
                if (cnt_reg == 5'd2) begin
                    state_next = DATA;
                    cnt_next   = 5'd0;
                end else begin
                    cnt_next = cnt_reg + 5'd1;
                end
            end
            DATA: begin
                if (cnt_reg == 5'd17) begin
                    state_next = GAP;
                    cnt_next   = 5'd0;
                end else begin
                    cnt_next = cnt_reg + 5'd1;
                end
            end
            GAP: begin
                cnt_next = 5'd0;
                // The last gap goes to DONE. This stops k from wrapping back to 0.
                if (k_reg == 3'd7) begin
                    state_next = DONE;
                end else begin
                    state_next = ADDR;
                    k_next     = k_reg + 3'd1;
                end
            end
            DONE: begin
                state_next = DONE;
                cnt_next   = 5'd0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 5'd0;
                k_next     = 3'd0;
            end
        endcase
    end

    // Output decode for the upcoming cycle. The RAM address runs two cycles
    // ahead of sd, and RB1_Q is taken only when the next cycle is a data bit.
    always_comb begin
        sen_next  = 1'b1;
        sd_next   = 1'b0;
        done_next = (state_next == DONE);
        addr_next = 5'd0;
        if (state_next == ADDR) begin
            sen_next = 1'b0;
            case (cnt_next[1:0])
                2'd0:    sd_next = k_next[2];
                2'd1:    sd_next = k_next[1];
                default: sd_next = k_next[0];
            endcase
            if (cnt_next == 5'd1) addr_next = 5'd0;
            if (cnt_next == 5'd2) addr_next = 5'd1;
        end else if (state_next == DATA) begin
            sen_next = 1'b0;
            sd_next  = RB1_Q[3'd7 - k_next];
            if (cnt_next <= 5'd15) addr_next = cnt_next + 5'd2;
        end
    end

    // Register the state and all link and RAM outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 5'd0;
            k_reg     <= 3'd0;
            sen       <= 1'b1;
            sd        <= 1'b0;
            RB1_A     <= 5'd0;
            S1_done   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            k_reg     <= k_next;
            sen       <= sen_next;
            sd        <= sd_next;
            RB1_A     <= addr_next;
            S1_done   <= done_next;
        end
    end

endmodule

// File: tb/tb_s1_serial_tx.sv
// Directed testbench for s1_serial_tx. It models RB1 as a synchronous RAM and
// records every link cycle. It then decodes the packets and checks them against
// hand-computed transpose results and the timing of the link protocol.
module tb_s1_serial_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] RB1_Q;
    logic       RB1_RW;
    logic [4:0] RB1_A;
    logic       sen;
    logic       sd;
    logic       S1_done;

    logic [7:0] mem [0:17];
    logic       cap_sen  [0:199];
    logic       cap_sd   [0:199];
    logic [4:0] cap_a    [0:199];
    logic       cap_done [0:199];

    int errors = 0;
    int checks = 0;

    s1_serial_tx dut (
        .clk     (clk),
        .rst     (rst),
        .RB1_Q   (RB1_Q),
        .RB1_RW  (RB1_RW),
        .RB1_A   (RB1_A),
        .sen     (sen),
        .sd      (sd),
        .S1_done (S1_done)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM model. The address is sampled at the edge, and the
    // data is valid for the whole following cycle.
    always @(posedge clk) RB1_Q <= (RB1_A < 5'd18) ? mem[RB1_A] : 8'h00;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Capture n cycles. Release rst at a negedge first, so the next posedge is edge 0.
    task automatic release_and_capture(input int n);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            @(negedge clk);
            cap_sen[c]  = sen;
            cap_sd[c]   = sd;
            cap_a[c]    = RB1_A;
            cap_done[c] = S1_done;
        end
    endtask

    function automatic int pkt_addr(input int k);
        int b = 1 + 22 * k;
        return {29'd0, cap_sd[b], cap_sd[b+1], cap_sd[b+2]};
    endfunction

    function automatic int pkt_data(input int k);
        int b = 1 + 22 * k;
        int d = 0;
        for (int j = 0; j < 18; j++) d = (d << 1) | int'(cap_sd[b+3+j]);
        return d;
    endfunction

    // Protocol errors for one packet: sen low for 21 cycles, then one high
    // gap cycle, and RB1_A = i in cycle b+1+i.
    function automatic int pkt_proto_errs(input int k);
        int b = 1 + 22 * k;
        int e = 0;
        for (int j = 0; j < 21; j++) if (cap_sen[b+j] !== 1'b0) e++;
        if (cap_sen[b+21] !== 1'b1) e++;
        for (int i = 0; i < 18; i++) if (cap_a[b+1+i] !== 5'(i)) e++;
        return e;
    endfunction

    initial begin
        // Reset state while clock runs
        for (int i = 0; i < 18; i++) mem[i] = 8'h80;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sen",  int'(sen), 1);
        check("rst_sd",   int'(sd), 0);
        check("rst_rw",   int'(RB1_RW), 1);
        check("rst_a",    int'(RB1_A), 0);
        check("rst_done", int'(S1_done), 0);

        // Transpose check with all bytes 8'h80
        release_and_capture(180);
        check("c0_sen_idle", int'(cap_sen[0]), 1);
        check("c1_sen_low",  int'(cap_sen[1]), 0);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t80_p%0d_addr", k), pkt_addr(k), k);
            check($sformatf("t80_p%0d_data", k), pkt_data(k), (k == 0) ? 18'h3FFFF : 0);
            check($sformatf("t80_p%0d_proto", k), pkt_proto_errs(k), 0);
        end
        check("done_c176", int'(cap_done[176]), 0);
        check("done_c177", int'(cap_done[177]), 1);
        check("done_c179", int'(cap_done[179]), 1);
        check("gap_c176_sen", int'(cap_sen[176]), 1);
        check("post_sen", int'(cap_sen[178]), 1);
        check("post_sd",  int'(cap_sd[178]), 0);

        // Pattern check: RB1[i] = i
        rst = 1'b1;
        for (int i = 0; i < 18; i++) mem[i] = 8'(i);
        repeat (2) @(posedge clk);
        release_and_capture(180);
        check("pat_p7_addr", pkt_addr(7), 7);
        check("pat_p7_data", pkt_data(7), 18'b010101010101010101);
        check("pat_p3_addr", pkt_addr(3), 3);
        check("pat_p3_data", pkt_data(3), 18'b000000000000000011);
        check("pat_p4_data", pkt_data(4), 18'b000000001111111100);
        check("pat_p0_data", pkt_data(0), 0);
        check("pat_done", int'(cap_done[177]), 1);

        // Mid-packet reset in cycle 60 (packet 2 DATA)
        rst = 1'b1;
        for (int i = 0; i < 18; i++) mem[i] = (i % 2 == 0) ? 8'h80 : 8'h7F;
        repeat (2) @(posedge clk);
        release_and_capture(61);
        check("mid_c60_sen_before", int'(cap_sen[60]), 0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_sen",  int'(sen), 1);
        check("mid_rst_sd",   int'(sd), 0);
        check("mid_rst_a",    int'(RB1_A), 0);
        check("mid_rst_done", int'(S1_done), 0);
        release_and_capture(45);
        check("mid_p0_addr", pkt_addr(0), 0);
        check("mid_p0_data", pkt_data(0), 18'h2AAAA);
        check("mid_p1_addr", pkt_addr(1), 1);
        check("mid_p1_data", pkt_data(1), 18'h15555);
        check("mid_p0_proto", pkt_proto_errs(0), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
